// File: rtl/gs_sweep_if.sv
// gs_sweep_if: row-store, core and x-update buses between the sweep scheduler and its environment.
interface gs_sweep_if;
  logic         o_row_req;
  logic [2:0]   o_row_idx;
  logic         i_row_valid;
  logic [55:0]  i_row_a;
  logic [7:0]   i_row_b;
  logic [31:0]  i_row_adown;
  logic         o_core_rst;
  logic         o_core_valid;
  logic [55:0]  o_core_a;
  logic [7:0]   o_core_b;
  logic [31:0]  o_core_adown;
  logic [223:0] o_core_x;
  logic         i_core_ovalid;
  logic [31:0]  i_core_xnext;
  logic         o_x_wr;
  logic [2:0]   o_x_idx;
  logic [31:0]  o_x_data;
  modport master (
    output o_row_req, o_row_idx, o_core_rst, o_core_valid, o_core_a, o_core_b,
           o_core_adown, o_core_x, o_x_wr, o_x_idx, o_x_data,
    input  i_row_valid, i_row_a, i_row_b, i_row_adown, i_core_ovalid, i_core_xnext
  );
  modport slave (
    input  o_row_req, o_row_idx, o_core_rst, o_core_valid, o_core_a, o_core_b,
           o_core_adown, o_core_x, o_x_wr, o_x_idx, o_x_data,
    output i_row_valid, i_row_a, i_row_b, i_row_adown, i_core_ovalid, i_core_xnext
  );
endinterface

// File: rtl/gs_sweep_scheduler.sv
// gs_sweep_scheduler: sequences the single-row Gauss-Seidel core over 8 unknowns for i_iters sweeps.
// GS_CONVERGE_EN adds i_tol/o_converged and ends the job early once a whole sweep stays within tolerance.
module gs_sweep_scheduler #(
  parameter int N      = 8,
  parameter int ITER_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ITER_W-1:0] i_iters,
`ifdef GS_CONVERGE_EN
  input  logic [31:0]       i_tol,
  output logic              o_converged,
`endif
  output logic              o_busy,
  output logic              o_done,
  gs_sweep_if.master        io_bus
);
  if (N != 8) begin : g_n_check
    $error("gs_sweep_scheduler: N must be 8");
  end
  typedef enum logic [2:0] {IDLE, FETCH, LAUNCH, WAIT, WRITE, DONE} state_t;
  state_t              r_state, w_next;
  logic [31:0]         r_x [0:N-1];
  logic [2:0]          r_row;
  logic [ITER_W-1:0]   r_sweep, r_iters, w_sweep_inc;
  logic                r_core_rst;
  logic [55:0]         r_core_a;
  logic [7:0]          r_core_b;
  logic [31:0]         r_core_adown, w_x_old;
  logic [223:0]        r_core_x, w_xpack;
  logic                w_last;
  assign w_sweep_inc = r_sweep + 1'b1;
  assign w_x_old     = r_x[r_row];
  // Off-diagonal x values skip the current row, lowest index in the top word.
  for (genvar k = 0; k < 7; k++) begin : g_pack
    assign w_xpack[223-32*k -: 32] = (r_row > 3'(k)) ? r_x[k] : r_x[k+1];
  end
`ifdef GS_CONVERGE_EN
  logic        r_conv, r_converged, w_conv_next;
  logic [32:0] w_diff, w_abs;
  assign w_diff      = {io_bus.i_core_xnext[31], io_bus.i_core_xnext} - {w_x_old[31], w_x_old};
  assign w_abs       = w_diff[32] ? -w_diff : w_diff;
  assign w_conv_next = r_conv && (w_abs <= {1'b0, i_tol});
  assign w_last      = (r_row == 3'd7) && ((w_sweep_inc == r_iters) || w_conv_next);
  assign o_converged = r_converged;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_conv      <= 1'b1;
      r_converged <= 1'b0;
    end else if (r_state == IDLE && i_start) begin
      r_conv      <= 1'b1;
      r_converged <= 1'b0;
    end else if (r_state == WRITE) begin
      r_conv <= (r_row == 3'd7) ? 1'b1 : w_conv_next;
      if (w_last) r_converged <= w_conv_next;
    end
  end
`else
  assign w_last = (r_row == 3'd7) && (w_sweep_inc == r_iters);
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = (i_iters == '0) ? DONE : FETCH;
      FETCH:   if (io_bus.i_row_valid) w_next = LAUNCH;
      LAUNCH:  w_next = WAIT;
      WAIT:    if (io_bus.i_core_ovalid) w_next = WRITE;
      WRITE:   w_next = w_last ? DONE : FETCH;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_row        <= '0;
      r_sweep      <= '0;
      r_iters      <= '0;
      r_core_rst   <= 1'b1;
      r_core_a     <= '0;
      r_core_b     <= '0;
      r_core_adown <= '0;
      r_core_x     <= '0;
      for (int k = 0; k < N; k++) r_x[k] <= '0;
    end else begin
      r_state    <= w_next;
      r_core_rst <= (w_next == IDLE) || (w_next == WRITE) || (w_next == DONE);
      if (r_state == IDLE && i_start) begin
        r_iters <= i_iters;
        r_row   <= '0;
        r_sweep <= '0;
        for (int k = 0; k < N; k++) r_x[k] <= '0;
      end
      if (r_state == FETCH && io_bus.i_row_valid) begin
        r_core_a     <= io_bus.i_row_a;
        r_core_b     <= io_bus.i_row_b;
        r_core_adown <= io_bus.i_row_adown;
        r_core_x     <= w_xpack;
      end
      if (r_state == WRITE) begin
        r_x[r_row] <= io_bus.i_core_xnext;
        r_row      <= r_row + 3'd1;
        if (r_row == 3'd7) r_sweep <= w_sweep_inc;
      end
    end
  end
  assign o_busy              = (r_state != IDLE) && (r_state != DONE);
  assign o_done              = r_state == DONE;
  assign io_bus.o_row_req    = r_state == FETCH;
  assign io_bus.o_row_idx    = r_row;
  assign io_bus.o_core_rst   = r_core_rst;
  assign io_bus.o_core_valid = r_state == LAUNCH;
  assign io_bus.o_core_a     = r_core_a;
  assign io_bus.o_core_b     = r_core_b;
  assign io_bus.o_core_adown = r_core_adown;
  assign io_bus.o_core_x     = r_core_x;
  assign io_bus.o_x_wr       = r_state == WRITE;
  assign io_bus.o_x_idx      = r_row;
  assign io_bus.o_x_data     = io_bus.i_core_xnext;
endmodule
